// File: rtl/tdm_demux_rx.sv
// Receive side of the 4:1 single-wire TDM link: tracks the slot count from frame_sync,
// deserialises one bit per slot and presents each complete frame as a parallel word.
module tdm_demux_rx #(
    parameter int N_CH  = 4,
    parameter int SEL_W = $clog2(N_CH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             line_in,
    input  logic             frame_sync,
    output logic [SEL_W-1:0] sel_out,
    output logic [N_CH-1:0]  data_out,
    output logic             data_valid,
    output logic             frame_err,
    output logic             locked
);

    typedef enum logic {
        HUNT = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(N_CH - 1);
    localparam logic [SEL_W-1:0] SLOT_ONE  = SEL_W'(1);

    state_t           state_q,  state_d;
    logic [SEL_W-1:0] slot_q,   slot_d;
    logic [N_CH-1:0]  shadow_q, shadow_d;
    logic [N_CH-1:0]  data_q,   data_d;
    logic             valid_q,  valid_d;
    logic             err_q,    err_d;
    logic             locked_q, locked_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= HUNT;
            slot_q   <= '0;
            shadow_q <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            slot_q   <= slot_d;
            shadow_q <= shadow_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            locked_q <= locked_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        slot_d   = slot_q;
        shadow_d = shadow_q;
        data_d   = data_q;
        valid_d  = 1'b0;
        err_d    = 1'b0;
        locked_d = locked_q;

        case (state_q)
            HUNT: begin
                if (frame_sync) begin
                    shadow_d[0] = line_in;
                    slot_d      = SLOT_ONE;
                    state_d     = RUN;
                end
            end
            RUN: begin
                if (frame_sync) begin
                    // A sync anywhere but slot 0 abandons the partial frame and restarts here.
                    if (slot_q != '0) begin
                        err_d    = 1'b1;
                        locked_d = 1'b0;
                    end
                    shadow_d[0] = line_in;
                    slot_d      = SLOT_ONE;
                end else if (slot_q == '0) begin
                    err_d    = 1'b1;
                    locked_d = 1'b0;
                    state_d  = HUNT;
                    slot_d   = '0;
                end else begin
                    shadow_d[slot_q] = line_in;
                    if (slot_q == LAST_SLOT) begin
                        data_d   = {line_in, shadow_q[N_CH-2:0]};
                        valid_d  = 1'b1;
                        locked_d = 1'b1;
                        slot_d   = '0;
                    end else begin
                        slot_d = slot_q + SLOT_ONE;
                    end
                end
            end
            default: begin
                state_d = HUNT;
                slot_d  = '0;
            end
        endcase
    end

    assign sel_out    = slot_q;
    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign frame_err  = err_q;
    assign locked     = locked_q;

endmodule

// File: tb/tb_tdm_demux_rx.sv
// Bench for tdm_demux_rx: directed frame scenarios plus randomized traffic against a frame-collector model.
module tb_tdm_demux_rx;

    localparam int N_CH  = 4;
    localparam int SEL_W = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             line_in;
    logic             frame_sync;
    logic [SEL_W-1:0] sel_out;
    logic [N_CH-1:0]  data_out;
    logic             data_valid;
    logic             frame_err;
    logic             locked;

    int vectors = 0;
    int miscompares = 0;

    // Model: a frame is the list of bits gathered since the last accepted sync.
    bit              m_hunt = 1'b1;
    bit              m_frame[$];
    logic [N_CH-1:0] m_data = '0;
    logic            m_valid = 1'b0;
    logic            m_err = 1'b0;
    logic            m_locked = 1'b0;

    tdm_demux_rx #(.N_CH(N_CH)) dut (
        .clk        (clk),
        .rst        (rst),
        .line_in    (line_in),
        .frame_sync (frame_sync),
        .sel_out    (sel_out),
        .data_out   (data_out),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .locked     (locked)
    );

    always #5 clk = ~clk;

    task automatic model_edge(input logic r, input logic l, input logic s);
        if (r) begin
            m_hunt = 1'b1;
            m_frame.delete();
            m_data = '0;
            m_valid = 1'b0;
            m_err = 1'b0;
            m_locked = 1'b0;
        end else begin
            m_valid = 1'b0;
            m_err = 1'b0;
            if (m_hunt) begin
                if (s) begin
                    m_frame.delete();
                    m_frame.push_back(l);
                    m_hunt = 1'b0;
                end
            end else if (s) begin
                if (m_frame.size() != 0) begin
                    m_err = 1'b1;
                    m_locked = 1'b0;
                end
                m_frame.delete();
                m_frame.push_back(l);
            end else if (m_frame.size() == 0) begin
                m_err = 1'b1;
                m_locked = 1'b0;
                m_hunt = 1'b1;
            end else begin
                m_frame.push_back(l);
                if (m_frame.size() == N_CH) begin
                    for (int i = 0; i < N_CH; i++) m_data[i] = m_frame[i];
                    m_valid = 1'b1;
                    m_locked = 1'b1;
                    m_frame.delete();
                end
            end
        end
    endtask

    // Apply one cycle of inputs, clock it in, and sample #1 after the edge.
    task automatic cyc(input logic r, input logic l, input logic s);
        rst = r;
        line_in = l;
        frame_sync = s;
        @(posedge clk);
        model_edge(r, l, s);
        #1;
    endtask

    task automatic send_frame(input logic [N_CH-1:0] bits);
        for (int i = 0; i < N_CH; i++) cyc(1'b0, bits[i], (i == 0));
    endtask

    task automatic test_reset;
        cyc(1'b1, 1'b1, 1'b1);
        cyc(1'b1, 1'b0, 1'b1);
        vectors++;
        if ({sel_out, data_out, data_valid, frame_err, locked} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got sel=%0d data=%b v=%b e=%b l=%b, want all 0",
                     sel_out, data_out, data_valid, frame_err, locked);
        end
    endtask

    task automatic test_single_frame;
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        vectors++;
        if (sel_out !== 2'd1) begin
            miscompares++;
            $display("FAIL single_sel_after_sync: got %0d want 1", sel_out);
        end
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        vectors++;
        if (data_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL single_early_valid: got %b want 0", data_valid);
        end
        cyc(1'b0, 1'b0, 1'b0);
        vectors++;
        if (data_valid !== 1'b1 || data_out !== 4'b0110 || locked !== 1'b1) begin
            miscompares++;
            $display("FAIL single_frame: got v=%b data=%b l=%b want v=1 data=0110 l=1",
                     data_valid, data_out, locked);
        end
        cyc(1'b0, 1'b0, 1'b1);
        vectors++;
        if (data_valid !== 1'b0 || frame_err !== 1'b0) begin
            miscompares++;
            $display("FAIL single_pulse_width: got v=%b e=%b want 0 0", data_valid, frame_err);
        end
    endtask

    task automatic test_back_to_back;
        logic [N_CH-1:0] frames [3];
        int pulses;
        int errs;
        frames[0] = 4'b0110;
        frames[1] = 4'b1001;
        frames[2] = 4'b1111;
        pulses = 0;
        errs = 0;
        cyc(1'b1, 1'b0, 1'b0);
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < N_CH; i++) begin
                cyc(1'b0, frames[f][i], (i == 0));
                if (data_valid === 1'b1) pulses++;
                if (frame_err !== 1'b0) errs++;
            end
            vectors++;
            if (data_valid !== 1'b1 || data_out !== frames[f]) begin
                miscompares++;
                $display("FAIL b2b_frame%0d: got v=%b data=%b want v=1 data=%b",
                         f, data_valid, data_out, frames[f]);
            end
        end
        vectors++;
        if (pulses != 3 || errs != 0) begin
            miscompares++;
            $display("FAIL b2b_counts: got pulses=%0d errs=%0d want 3 0", pulses, errs);
        end
    endtask

    task automatic test_missing_sync;
        cyc(1'b1, 1'b0, 1'b0);
        send_frame(4'b0110);
        cyc(1'b0, 1'b1, 1'b0);
        vectors++;
        if (frame_err !== 1'b1 || locked !== 1'b0 || data_out !== 4'b0110 || data_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL missing_sync: got e=%b l=%b data=%b v=%b want e=1 l=0 data=0110 v=0",
                     frame_err, locked, data_out, data_valid);
        end
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        vectors++;
        if (sel_out !== 2'd0 || frame_err !== 1'b0 || data_out !== 4'b0110) begin
            miscompares++;
            $display("FAIL missing_sync_hunt: got sel=%0d e=%b data=%b want sel=0 e=0 data=0110",
                     sel_out, frame_err, data_out);
        end
    endtask

    task automatic test_early_sync;
        int valids;
        valids = 0;
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b1);
        vectors++;
        if (frame_err !== 1'b1 || locked !== 1'b0 || data_valid !== 1'b0 || sel_out !== 2'd1) begin
            miscompares++;
            $display("FAIL early_sync: got e=%b l=%b v=%b sel=%0d want e=1 l=0 v=0 sel=1",
                     frame_err, locked, data_valid, sel_out);
        end
        cyc(1'b0, 1'b0, 1'b0);
        if (data_valid === 1'b1) valids++;
        cyc(1'b0, 1'b1, 1'b0);
        if (data_valid === 1'b1) valids++;
        cyc(1'b0, 1'b0, 1'b0);
        vectors++;
        if (valids != 0 || data_valid !== 1'b1 || data_out !== 4'b0101 || locked !== 1'b1) begin
            miscompares++;
            $display("FAIL early_sync_refill: got stray=%0d v=%b data=%b l=%b want 0 1 0101 1",
                     valids, data_valid, data_out, locked);
        end
    endtask

    task automatic test_reset_mid_frame;
        int valids;
        valids = 0;
        cyc(1'b1, 1'b0, 1'b0);
        send_frame(4'b1011);
        cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        vectors++;
        if ({sel_out, data_out, data_valid, frame_err, locked} !== '0) begin
            miscompares++;
            $display("FAIL reset_mid: got sel=%0d data=%b v=%b e=%b l=%b want all 0",
                     sel_out, data_out, data_valid, frame_err, locked);
        end
        cyc(1'b0, 1'b1, 1'b0);
        if (data_valid === 1'b1 || sel_out !== 2'd0) valids++;
        cyc(1'b0, 1'b1, 1'b0);
        if (data_valid === 1'b1 || sel_out !== 2'd0) valids++;
        vectors++;
        if (valids != 0 || data_out !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_mid_ignore: got bad_cycles=%0d data=%b want 0 0000", valids, data_out);
        end
        send_frame(4'b1100);
        vectors++;
        if (data_valid !== 1'b1 || data_out !== 4'b1100) begin
            miscompares++;
            $display("FAIL reset_mid_resync: got v=%b data=%b want 1 1100", data_valid, data_out);
        end
    endtask

    task automatic test_random;
        int pos;
        logic r, l, s;
        pos = 0;
        cyc(1'b1, 1'b0, 1'b0);
        for (int n = 0; n < 600; n++) begin
            r = ($urandom_range(0, 79) == 0);
            l = 1'($urandom);
            s = (pos == 0) ^ ($urandom_range(0, 24) == 0);
            pos = (pos + 1) % N_CH;
            cyc(r, l, s);
            vectors++;
            if (sel_out !== SEL_W'(m_frame.size()) || data_out !== m_data || data_valid !== m_valid ||
                frame_err !== m_err || locked !== m_locked) begin
                miscompares++;
                $display("FAIL random_cycle%0d: got sel=%0d data=%b v=%b e=%b l=%b want sel=%0d data=%b v=%b e=%b l=%b",
                         n, sel_out, data_out, data_valid, frame_err, locked,
                         m_frame.size(), m_data, m_valid, m_err, m_locked);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        line_in = 1'b0;
        frame_sync = 1'b0;
        test_reset;
        test_single_frame;
        test_back_to_back;
        test_missing_sync;
        test_early_sync;
        test_reset_mid_frame;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
